// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two async read ports, one sync write port, bypass and busy-bit scoreboard
module reg_file_sb #(
    parameter int WIDTH_REG = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    a1,
    input  logic [ADDR_W-1:0]    a2,
    output logic [WIDTH_REG-1:0] rd1,
    output logic [WIDTH_REG-1:0] rd2,
    output logic                 busy1,
    output logic                 busy2,
    input  logic [ADDR_W-1:0]    a3,
    input  logic [WIDTH_REG-1:0] wd3,
    input  logic                 we3,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_a,
    output logic                 rsv_err,
    output logic                 all_idle
);
    logic [WIDTH_REG-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  busy_next;
    logic                 wr_ok;
    logic                 byp1;
    logic                 byp2;
    logic                 rsv_clash;

    assign wr_ok     = we3 && a3 != '0;
    assign byp1      = BYPASS && wr_ok && a3 == a1;
    assign byp2      = BYPASS && wr_ok && a3 == a2;
    assign rsv_clash = rsv_en && rsv_a != '0 && busy[rsv_a] && !(we3 && a3 == rsv_a);

    assign rd1   = byp1 ? wd3 : (a1 == '0) ? '0 : regs[a1];
    assign rd2   = byp2 ? wd3 : (a2 == '0) ? '0 : regs[a2];
    assign busy1 = byp1 ? 1'b0 : busy[a1];
    assign busy2 = byp2 ? 1'b0 : busy[a2];

    // Next busy bits: a reservation beats a release of the same register; r0 never busy
    always_comb begin
        busy_next = '0;
        for (int r = 1; r < NUM_REGS; r++)
            busy_next[r] = (rsv_en && rsv_a == ADDR_W'(r)) ? 1'b1 :
                           (we3 && a3 == ADDR_W'(r)) ? 1'b0 : busy[r];
    end

    // Register data: writes to r0 are dropped so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (wr_ok) begin
            regs[a3] <= wd3;
        end
    end

    // Scoreboard state, sticky reservation error and registered idle flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            rsv_err  <= 1'b0;
            all_idle <= 1'b1;
        end else begin
            busy     <= busy_next;
            rsv_err  <= rsv_err | rsv_clash;
            all_idle <= ~|busy_next;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb with directed vectors
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  a1, a2, a3, rsv_a;
    logic [31:0] wd3;
    logic        we3, rsv_en;
    logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
    logic        busy1, busy2, rsv_err, all_idle;
    logic        busy1_nb, busy2_nb, rsv_err_nb, all_idle_nb;

    typedef struct {
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.WIDTH_REG(32), .NUM_REGS(32), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .a3(a3), .wd3(wd3), .we3(we3),
        .rsv_en(rsv_en), .rsv_a(rsv_a), .rsv_err(rsv_err), .all_idle(all_idle)
    );

    reg_file_sb #(.WIDTH_REG(32), .NUM_REGS(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1_nb), .rd2(rd2_nb),
        .busy1(busy1_nb), .busy2(busy2_nb), .a3(a3), .wd3(wd3), .we3(we3),
        .rsv_en(rsv_en), .rsv_a(rsv_a), .rsv_err(rsv_err_nb), .all_idle(all_idle_nb)
    );

    function automatic logic [31:0] actual(int sig);
        case (sig)
            0: return rd1;
            1: return rd2;
            2: return {31'b0, busy1};
            3: return {31'b0, busy2};
            4: return {31'b0, rsv_err};
            5: return {31'b0, all_idle};
            6: return rd1_nb;
            default: return {31'b0, busy1_nb};
        endcase
    endfunction

    // Monitor: drain every expectation queued for this cycle, away from the rising edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = actual(e.sig);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic expect_val(int sig, logic [31:0] v, string n);
        q.push_back('{sig, v, n});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we3 = 0; rsv_en = 0; a3 = 0; wd3 = 0; rsv_a = 0;
    endtask

    initial begin
        rst_n = 0; a1 = 0; a2 = 0;
        idle();
        step();
        step();
        rst_n = 1;
        // 1: everything reads zero and idle after reset
        expect_val(4, 0, "rst_rsv_err");
        expect_val(5, 1, "rst_all_idle");
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            expect_val(0, 0, "rst_rd1");
            expect_val(1, 0, "rst_rd2");
            expect_val(2, 0, "rst_busy1");
            expect_val(3, 0, "rst_busy2");
            step();
        end
        // 2: basic write then read, r0 write dropped
        a1 = 0; a2 = 0;
        we3 = 1; a3 = 5; wd3 = 32'hDEAD_BEEF;
        step();
        idle(); a1 = 5;
        expect_val(0, 32'hDEAD_BEEF, "wr5_rd1");
        expect_val(6, 32'hDEAD_BEEF, "wr5_rd1_nb");
        step();
        we3 = 1; a3 = 0; wd3 = 32'h1234;
        step();
        idle(); a1 = 0; a2 = 0;
        expect_val(1, 0, "r0_rd2");
        expect_val(0, 0, "r0_rd1");
        step();
        // 3: same-cycle bypass vs no bypass
        we3 = 1; a3 = 7; wd3 = 32'hA5A5_A5A5; a1 = 7;
        expect_val(0, 32'hA5A5_A5A5, "byp_rd1");
        expect_val(6, 0, "nobyp_rd1_old");
        step();
        idle(); a1 = 7;
        expect_val(0, 32'hA5A5_A5A5, "r7_rd1");
        expect_val(6, 32'hA5A5_A5A5, "r7_rd1_nb");
        step();
        // 4: reserve, visible next cycle, release by write
        rsv_en = 1; rsv_a = 3; a1 = 3;
        expect_val(2, 0, "rsv3_same_cycle_busy1");
        expect_val(5, 1, "rsv3_same_cycle_idle");
        step();
        idle(); a1 = 3;
        expect_val(2, 1, "rsv3_busy1");
        expect_val(7, 1, "rsv3_busy1_nb");
        expect_val(5, 0, "rsv3_all_idle");
        step();
        we3 = 1; a3 = 3; wd3 = 32'h33;
        expect_val(2, 0, "wb3_byp_busy1");
        expect_val(7, 1, "wb3_nobyp_busy1");
        expect_val(0, 32'h33, "wb3_byp_rd1");
        step();
        idle(); a1 = 3;
        expect_val(2, 0, "rel3_busy1");
        expect_val(5, 1, "rel3_all_idle");
        expect_val(0, 32'h33, "rel3_rd1");
        step();
        rsv_en = 1; rsv_a = 3;
        step();
        rsv_en = 1; rsv_a = 3; we3 = 1; a3 = 3; wd3 = 32'h44;
        step();
        idle(); a1 = 3;
        expect_val(2, 1, "rerv3_busy1");
        expect_val(4, 0, "rerv3_rsv_err");
        expect_val(5, 0, "rerv3_all_idle");
        expect_val(0, 32'h44, "rerv3_rd1");
        step();
        we3 = 1; a3 = 3;
        step();
        idle(); a1 = 0;
        rsv_en = 1; rsv_a = 0;
        step();
        idle(); a1 = 3;
        expect_val(2, 0, "rel3b_busy1");
        expect_val(5, 1, "rsv0_ignored_idle");
        expect_val(4, 0, "rsv0_no_err");
        step();
        // 5: double reservation sets sticky error
        rsv_en = 1; rsv_a = 9;
        step();
        rsv_en = 1; rsv_a = 9;
        step();
        idle();
        expect_val(4, 1, "dbl9_rsv_err");
        step();
        we3 = 1; a3 = 9;
        step();
        idle();
        expect_val(4, 1, "dbl9_err_sticky");
        expect_val(5, 1, "dbl9_rel_idle");
        step();
        // 6: async reset mid-operation
        rsv_en = 1; rsv_a = 4;
        step();
        rsv_en = 1; rsv_a = 4; we3 = 1; a3 = 4; wd3 = 32'h1;
        step();
        idle(); a1 = 4; a2 = 7;
        expect_val(0, 1, "pre_rst_rd1");
        expect_val(2, 1, "pre_rst_busy1");
        expect_val(5, 0, "pre_rst_idle");
        step();
        rst_n = 0;
        expect_val(0, 0, "async_rst_rd1");
        expect_val(2, 0, "async_rst_busy1");
        expect_val(1, 0, "async_rst_rd2");
        expect_val(4, 0, "async_rst_rsv_err");
        expect_val(5, 1, "async_rst_idle");
        step();
        rst_n = 1;
        expect_val(0, 0, "post_rst_rd1");
        expect_val(1, 0, "post_rst_rd2");
        step();
        step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
